// File: rtl/load_store_unit.sv
// Load/store unit: turns a decoded access width into one byte-enabled data-memory
// transaction at a time, returning an extended load result or a store completion.
module load_store_unit #(
`ifdef BIT_COUNT_64
  parameter int XLEN    = 64,
`else
  parameter int XLEN    = 32,
`endif
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_trunc,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int BE_W = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; mem_ack completes the request held on mem_req.
  logic accept, ack_take, timeout_take;

  logic              write_q;
  logic [XLEN-1:0]   addr_q;
  logic [BE_W-1:0]   be_q;
  logic [XLEN-1:0]   wdata_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [7:0]        cnt_q;
  logic [XLEN-1:0]   rdata_q;
  logic              mis_q;
  logic              fault_q;

  // Size is log2 of the byte count: 0=byte, 1=half, 2=word, 3=dword.
  logic [1:0] dec_size;
  logic       dec_sign;
  logic       dec_legal;

  always_comb begin
    dec_size  = 2'd0;
    dec_sign  = 1'b0;
    dec_legal = 1'b1;
    case (req_trunc)
      3'd0: begin dec_size = 2'd0; dec_sign = 1'b1; end
      3'd1: begin dec_size = 2'd1; dec_sign = 1'b1; end
      3'd2: begin dec_size = 2'd2; dec_sign = 1'b1; end
      3'd3: dec_size = 2'd0;
      3'd4: dec_size = 2'd1;
      // Code 5 is WORD_UNSIGNED on 64-bit and NO_TRUNC on 32-bit; both are 4 unsigned bytes.
      3'd5: dec_size = 2'd2;
      3'd6: begin
        if (XLEN == 64) dec_size = 2'd3;
        else            dec_legal = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  logic [OFF_W-1:0] req_off;
  logic             off_bad;
  logic             req_misaligned;
  logic [BE_W-1:0]  be_base;
  logic [BE_W-1:0]  req_be;
  logic [XLEN-1:0]  req_wrep;

  assign req_off = req_addr[OFF_W-1:0];

  always_comb begin
    off_bad  = 1'b0;
    be_base  = '1;
    req_wrep = req_wdata;
    case (dec_size)
      2'd0: begin
        off_bad  = 1'b0;
        be_base  = BE_W'(1);
        req_wrep = {BE_W{req_wdata[7:0]}};
      end
      2'd1: begin
        off_bad  = req_off[0];
        be_base  = BE_W'(3);
        req_wrep = {(XLEN/16){req_wdata[15:0]}};
      end
      2'd2: begin
        off_bad  = |req_off[1:0];
        be_base  = BE_W'(15);
        req_wrep = {(XLEN/32){req_wdata[31:0]}};
      end
      default: begin
        off_bad  = |req_off;
        be_base  = '1;
        req_wrep = req_wdata;
      end
    endcase
  end

  assign req_misaligned = !dec_legal || off_bad;
  assign req_be = be_base << req_off;

  // Load extraction: move the addressed lane to bit 0, then mask and extend.
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            msb;
  logic [XLEN-1:0] load_ext;

  assign shifted = mem_rdata >> {off_q, 3'b000};
  assign mask = (XLEN'(1) << (7'd8 << size_q)) - XLEN'(1);

  always_comb begin
    msb = 1'b0;
    case (size_q)
      2'd0:    msb = shifted[7];
      2'd1:    msb = shifted[15];
      2'd2:    msb = shifted[31];
      default: msb = shifted[XLEN-1];
    endcase
  end

  assign load_ext = (shifted & mask) | ((sign_q && msb) ? ~mask : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    ack_take     = 1'b0;
    timeout_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = req_misaligned ? RESPOND : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          ack_take = 1'b1;
          state_d  = RESPOND;
        end else if (cnt_q == TO_LAST) begin
          timeout_take = 1'b1;
          state_d      = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      cnt_q   <= 8'd0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        addr_q  <= {req_addr[XLEN-1:OFF_W], OFF_W'(0)};
        be_q    <= req_be;
        wdata_q <= req_wrep;
        off_q   <= req_off;
        size_q  <= dec_size;
        sign_q  <= dec_sign;
        cnt_q   <= 8'd0;
        rdata_q <= '0;
        mis_q   <= req_misaligned;
        fault_q <= 1'b0;
      end
      if (state_q == ACCESS && !mem_ack && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      if (ack_take && !write_q) rdata_q <= load_ext;
      if (timeout_take) fault_q <= 1'b1;
    end
  end

  // Memory-side outputs are forced low outside ACCESS so a stale request never leaks.
  assign req_ready       = (state_q == IDLE);
  assign stall           = !req_ready;
  assign mem_req         = (state_q == ACCESS);
  assign mem_we          = mem_req && write_q;
  assign mem_addr        = mem_req ? addr_q  : '0;
  assign mem_be          = mem_req ? be_q    : '0;
  assign mem_wdata       = mem_req ? wdata_q : '0;
  assign resp_valid      = (state_q == RESPOND);
  assign resp_rdata      = resp_valid ? rdata_q : '0;
  assign resp_misaligned = resp_valid && mis_q;
  assign resp_fault      = resp_valid && fault_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32, TIMEOUT=4) with queue-based
// response and memory-request scoreboards.
module tb_load_store_unit;

  localparam int XLEN = 32;
  localparam int BE_W = 4;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_trunc;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_misaligned;
  logic              resp_fault;
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;
  logic [1:0]        dbg_state;

  load_store_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_trunc(req_trunc), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN+1:0]           exp_q[$];   // {misaligned, fault, rdata}
  logic [1+XLEN+BE_W+XLEN-1:0] mexp_q[$]; // {we, addr, be, wdata}
  int resp_cnt = 0;
  int last_resp_cycle = 0;
  int accept_cycle = 0;
  int mem_req_high = 0;
  logic mem_req_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [XLEN+1:0] e;
    logic [1+XLEN+BE_W+XLEN-1:0] me;
    if (reset_n && resp_valid) begin
      resp_cnt++;
      last_resp_cycle = cycle;
      check("stall_in_respond", 64'({stall, req_ready}), 64'(2'b10));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got rdata 0x%0h with nothing expected", resp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("resp", 64'({resp_misaligned, resp_fault, resp_rdata}), 64'(e));
      end
    end
    if (reset_n && mem_req && !mem_req_prev) begin
      if (mexp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_mem_req: got addr 0x%0h with nothing expected", mem_addr);
      end else begin
        me = mexp_q.pop_front();
        check("mem_ctrl", 64'({mem_we, mem_be, mem_addr}), 64'({me[68], me[35:32], me[67:36]}));
        check("mem_wdata", 64'(mem_wdata), 64'(me[31:0]));
      end
    end
    if (mem_req) mem_req_high = mem_req_prev ? mem_req_high + 1 : 1;
    mem_req_prev = mem_req;
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic w, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    int i;
    i = 0;
    while (!req_ready && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_ready_wait: got 0, expected 1 within 20 cycles");
    end
    req_valid = 1'b1;
    req_write = w;
    req_trunc = t;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    accept_cycle = cycle;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wdata = '0;
  endtask

  task automatic mem_respond(input int waits, input logic [31:0] rdata);
    repeat (waits) begin
      @(posedge clk); #1;
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic wait_resp(input string name, input int start, input int exp_lat);
    int i;
    i = 0;
    while (resp_cnt == start && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (resp_cnt == start) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_no_resp: got none, expected a response within 40 cycles", name);
    end else begin
      check({name, "_latency"}, 64'(last_resp_cycle + 1 - accept_cycle), 64'(exp_lat));
    end
  endtask

  // waits < 0 means the memory never acknowledges.
  task automatic txn(input string name, input logic w, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit has_mem, input logic [31:0] m_addr, input logic [3:0] m_be,
                     input logic [31:0] m_wdata, input int waits, input logic [31:0] rdata,
                     input logic [33:0] exp_resp, input int exp_lat);
    int start;
    exp_q.push_back(exp_resp);
    if (has_mem) mexp_q.push_back({w, m_addr, m_be, m_wdata});
    start = resp_cnt;
    issue(w, t, a, d);
    if (has_mem && waits >= 0) mem_respond(waits, rdata);
    wait_resp(name, start, exp_lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int saved;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_trunc = 3'd0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #3;
    check("reset_ctrl", 64'({req_ready, stall, resp_valid, mem_req, mem_we, mem_be, resp_misaligned, resp_fault}),
          64'(11'b100_0000_0000));
    check("reset_data", 64'(resp_rdata | mem_addr | mem_wdata), 64'(0));
    #20 reset_n = 1'b1;
    @(posedge clk); #1;

    //   name       w  trunc addr          wdata         mem m_addr        be       m_wdata       wait rdata         {mis,flt,rdata}          lat
    txn("lb_neg",   0, 3'd0, 32'h0000_1003, 32'h0,        1, 32'h0000_1000, 4'b1000, 32'h0,        0, 32'h80FF_FFFF, {2'b00, 32'hFFFF_FF80}, 2);
    txn("lb_pos",   0, 3'd0, 32'h0000_1002, 32'h0,        1, 32'h0000_1000, 4'b0100, 32'h0,        0, 32'h807F_1234, {2'b00, 32'h0000_007F}, 2);
    txn("lhu",      0, 3'd4, 32'h0000_2002, 32'h0,        1, 32'h0000_2000, 4'b1100, 32'h0,        0, 32'h8001_1234, {2'b00, 32'h0000_8001}, 2);
    txn("sb",       1, 3'd0, 32'h0000_3001, 32'hAABB_CCDD, 1, 32'h0000_3000, 4'b0010, 32'hDDDD_DDDD, 3, 32'h0,        {2'b00, 32'h0},         5);
    txn("lw_mis",   0, 3'd2, 32'h0000_0002, 32'h0,        0, 32'h0,         4'b0000, 32'h0,        0, 32'h0,         {2'b10, 32'h0},         1);
    txn("lh_wait",  0, 3'd1, 32'h0000_5002, 32'h0,        1, 32'h0000_5000, 4'b1100, 32'h0,        1, 32'h8001_1234, {2'b00, 32'hFFFF_8001}, 3);
    txn("lbu",      0, 3'd3, 32'h0000_6001, 32'h0,        1, 32'h0000_6000, 4'b0010, 32'h0,        0, 32'h0000_9A00, {2'b00, 32'h0000_009A}, 2);
    txn("sh",       1, 3'd1, 32'h0000_7002, 32'h1234_5678, 1, 32'h0000_7000, 4'b1100, 32'h5678_5678, 0, 32'h0,        {2'b00, 32'h0},         2);
    txn("sw",       1, 3'd2, 32'h0000_8004, 32'hCAFE_BABE, 1, 32'h0000_8004, 4'b1111, 32'hCAFE_BABE, 2, 32'h0,        {2'b00, 32'h0},         4);
    txn("no_trunc", 0, 3'd5, 32'h0000_9000, 32'h0,        1, 32'h0000_9000, 4'b1111, 32'h0,        0, 32'hDEAD_BEEF, {2'b00, 32'hDEAD_BEEF}, 2);
    txn("bad_enc",  0, 3'd7, 32'h0000_0000, 32'h0,        0, 32'h0,         4'b0000, 32'h0,        0, 32'h0,         {2'b10, 32'h0},         1);
    txn("lhu_odd",  0, 3'd4, 32'h0000_A001, 32'h0,        0, 32'h0,         4'b0000, 32'h0,        0, 32'h0,         {2'b10, 32'h0},         1);
    txn("timeout",  0, 3'd2, 32'h0000_B000, 32'h0,        1, 32'h0000_B000, 4'b1111, 32'h0,       -1, 32'h0,         {2'b01, 32'h0},         5);
    check("timeout_mem_req_cycles", 64'(mem_req_high), 64'(TIMEOUT));

    // A late ack arriving in IDLE must not produce another response.
    saved = resp_cnt;
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (4) @(negedge clk);
    check("late_ack_ignored", 64'(resp_cnt), 64'(saved));

    // Reset in the middle of an access abandons it with no response.
    mexp_q.push_back({1'b0, 32'h0000_B100, 4'b1111, 32'h0});
    issue(1'b0, 3'd2, 32'h0000_B100, 32'h0);
    @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_op", 64'({mem_req, stall, resp_valid, req_ready}), 64'(4'b0001));
    #20 reset_n = 1'b1;
    @(posedge clk); #1;
    txn("after_reset", 0, 3'd2, 32'h0000_C000, 32'h0, 1, 32'h0000_C000, 4'b1111, 32'h0, 0, 32'h1234_5678, {2'b00, 32'h1234_5678}, 2);

    repeat (3) @(negedge clk);
    check("resp_queue_empty", 64'(exp_q.size()), 64'(0));
    check("mem_queue_empty", 64'(mexp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory side of the load/store path. Consumes the access width encoded as `truncSrc` from the decode stage and turns it into a single-outstanding, byte-enabled data-memory transaction. On loads it returns sign/zero-extended results; on stores it returns a completion. It sits between the execute/memory pipeline stage and the data-memory port, and holds the pipeline via `stall` while a transaction is in flight.

## Interface
Parameters:
- `XLEN`, 32 (64 when `BIT_COUNT_64` is defined): data/address width.
- `TIMEOUT`, 16: cycles in ACCESS without `mem_ack` before an access fault; legal range 1..255.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  pipeline presents an access.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_trunc`  in  3  `truncSrc` encoding: BYTE=0, HALF_WORD=1, WORD=2, BYTE_UNSIGNED=3, HALF_WORD_UNSIGNED=4; 64-bit adds WORD_UNSIGNED=5 and NO_TRUNC=6; 32-bit has NO_TRUNC=5.
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data, right-aligned.
- `stall`  out  1  high while state is not IDLE.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  XLEN  extended load result; 0 for stores and faults.
- `resp_misaligned`  out  1  qualified by `resp_valid`.
- `resp_fault`  out  1  timeout fault, qualified by `resp_valid`.
- `mem_req`  out  1  registered request to data memory.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  XLEN  request address, aligned to XLEN/8 bytes.
- `mem_be`  out  XLEN/8  byte enables.
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_ack`  in  1  memory completes the request held on `mem_req`.
- `mem_rdata`  in  XLEN  full aligned word, valid when `mem_ack` is high.

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- Reset drives state to IDLE and every output to 0, except `req_ready`, which is 1 because the state is IDLE.
- **Sizes.** Byte for BYTE and BYTE_UNSIGNED. Half for HALF_WORD and HALF_WORD_UNSIGNED. Word (4 bytes) for WORD and WORD_UNSIGNED. XLEN/8 bytes for NO_TRUNC.
- **Misalignment.** An access is misaligned when `req_addr` is not a multiple of its size. Any encoding not listed above is also treated as misaligned.
- **IDLE.** On `req_valid` with `req_ready`, the unit latches the request.
  - Aligned access: go to ACCESS and drive `mem_req`.
  - Misaligned access: go straight to RESPOND with `resp_misaligned` set. No `mem_req` is issued.
- **ACCESS.** `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are held constant until `mem_ack`.
  - `mem_be` has the size's bits set, shifted by the offset `req_addr[log2(XLEN/8)-1:0]`.
  - `mem_wdata` is the low size bytes of `req_wdata` replicated across all lanes.
  - A saturating wait counter increments each cycle without ack.
- **Ack.** On `mem_ack`:
  - Loads: shift `mem_rdata` right by offset×8 and take the low size bytes. Sign-extend for BYTE/HALF_WORD/WORD; zero-extend for the unsigned variants and NO_TRUNC. Store the result in the response register.
  - Then go to RESPOND.
- **Timeout.** If the counter reaches `TIMEOUT` with no ack, drop `mem_req`, set `resp_fault`, and go to RESPOND.
- **RESPOND.** Assert `resp_valid` for exactly one cycle, then return to IDLE.
- **Ignored acks.** `mem_ack` is ignored outside ACCESS, including a late ack after a timeout.
- **Reset mid-operation.** Abandon the transaction immediately. Outputs return to reset values asynchronously; no response is produced.

## Timing
- Request accepted at edge N → `mem_req` high from N+1.
- `mem_ack` sampled at edge N+1+k → `resp_valid` high for cycle N+2+k. With k=0 this is a 2-cycle minimum latency.
- Misaligned request accepted at edge N → `resp_valid` during cycle N+1.
- Timeout: the fault response follows the TIMEOUT-th un-acked ACCESS cycle by one cycle. `mem_req` is low in the RESPOND cycle.
- `req_ready` is low from N+1 until the cycle after RESPOND, so there is one transaction in flight at most. Back-to-back throughput is one access per 3 cycles at zero wait states.
- `stall` equals the inverse of `req_ready`.

## Test plan
- **Load byte, signed.** XLEN=32 LB at addr 0x1003 → `mem_be`=4'b1000 and `mem_addr`=0x1000. `mem_rdata`=0x80FF_FFFF with immediate ack → `resp_rdata`=0xFFFF_FF80, two cycles after accept.
- **Load half, unsigned.** LHU at addr 0x2002 with `mem_rdata`=0x8001_1234 → `mem_be`=4'b1100 and `resp_rdata`=0x0000_8001.
- **Store byte.** SB at addr 0x3001 with data 0xAABB_CCDD → `mem_we`=1, `mem_be`=4'b0010, `mem_wdata`=0xDDDD_DDDD. Ack after 3 wait cycles → `resp_valid` 5 cycles after accept.
- **Misaligned.** LW at addr 0x0002 → no `mem_req`; `resp_valid` with `resp_misaligned`=1 one cycle after accept.
- **Timeout.** TIMEOUT=4 with `mem_ack` never asserted → `mem_req` held 4 cycles, then `resp_fault`=1 and `resp_rdata`=0. A late `mem_ack` in IDLE causes no second response.
- **Reset mid-operation.** Deassert `reset_n` in ACCESS → `mem_req`, `stall` and `resp_valid` drop to 0 at once, `req_ready`=1. After reset is released, a new request completes normally.
